// File: rtl/neuron_pkg.sv
// +--------------------------------------------------------------------+
// | neuron_pkg: shared types and defaults for the neuron operand path  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package neuron_pkg;

  localparam int LOADER_WIDTH = 32;
  localparam int LOADER_N_IN  = 3;
  localparam int IDX_W        = 2;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } loader_state_t;

  function automatic logic is_last_idx(input logic [IDX_W-1:0] i);
    return i == IDX_W'(LOADER_N_IN - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/operand_slot.sv
// +--------------------------------------------------------------------+
// | operand_slot: one (activation, weight, bias) register with enable  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module operand_slot
  import neuron_pkg::*;
#(
  parameter int WIDTH = LOADER_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic signed [WIDTH-1:0] a_in,
  input  logic signed [WIDTH-1:0] w_in,
  input  logic signed [WIDTH-1:0] b_in,
  output logic signed [WIDTH-1:0] a,
  output logic signed [WIDTH-1:0] w,
  output logic signed [WIDTH-1:0] b
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a <= '0;
      w <= '0;
      b <= '0;
    end else if (we) begin
      a <= a_in;
      w <= w_in;
      b <= b_in;
    end
  end

endmodule

`default_nettype wire

// File: rtl/neuron_operand_loader.sv
// +--------------------------------------------------------------------+
// | neuron_operand_loader: serial triplet stream to nine held operands |
// | Optional framing check: define NEURON_LOADER_FRAME_EN              |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module neuron_operand_loader
  import neuron_pkg::*;
#(
  parameter int WIDTH = LOADER_WIDTH,
  parameter int N_IN  = LOADER_N_IN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_a,
  input  logic signed [WIDTH-1:0] in_w,
  input  logic signed [WIDTH-1:0] in_b,
`ifdef NEURON_LOADER_FRAME_EN
  input  logic                    in_last,
  output logic                    frame_err,
`endif
  output logic signed [WIDTH-1:0] a_1,
  output logic signed [WIDTH-1:0] a_2,
  output logic signed [WIDTH-1:0] a_3,
  output logic signed [WIDTH-1:0] w_1,
  output logic signed [WIDTH-1:0] w_2,
  output logic signed [WIDTH-1:0] w_3,
  output logic signed [WIDTH-1:0] b_1,
  output logic signed [WIDTH-1:0] b_2,
  output logic signed [WIDTH-1:0] b_3,
  output logic                    out_valid,
  input  logic                    out_ready
);

  generate
    if (N_IN != 3) begin : g_bad_n_in
      $error("neuron_operand_loader: N_IN must be 3");
    end
  endgenerate

  loader_state_t state, state_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic beat, at_last, drop;
  logic [LOADER_N_IN-1:0] slot_we;

  logic signed [WIDTH-1:0] a_q [LOADER_N_IN];
  logic signed [WIDTH-1:0] w_q [LOADER_N_IN];
  logic signed [WIDTH-1:0] b_q [LOADER_N_IN];

  assign beat    = in_valid && in_ready;
  assign at_last = is_last_idx(idx);

`ifdef NEURON_LOADER_FRAME_EN
  // Early in_last abandons the partial vector instead of writing a slot.
  assign drop = beat && in_last && !at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
    end else if (beat && (in_last != at_last)) begin
      frame_err <= 1'b1;
    end
  end
`else
  assign drop = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      FILL: begin
        if (beat) begin
          if (drop) begin
            idx_next = '0;
          end else if (at_last) begin
            idx_next   = '0;
            state_next = HOLD;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_comb begin
    in_ready  = (state == FILL);
    out_valid = (state == HOLD);
    for (int k = 0; k < LOADER_N_IN; k++) begin
      slot_we[k] = beat && !drop && (idx == IDX_W'(k));
    end
  end

  generate
    for (genvar k = 0; k < LOADER_N_IN; k++) begin : g_slot
      operand_slot #(
        .WIDTH (WIDTH)
      ) u_slot (
        .clk  (clk),
        .rst  (rst),
        .we   (slot_we[k]),
        .a_in (in_a),
        .w_in (in_w),
        .b_in (in_b),
        .a    (a_q[k]),
        .w    (w_q[k]),
        .b    (b_q[k])
      );
    end
  endgenerate

  assign a_1 = a_q[0];
  assign a_2 = a_q[1];
  assign a_3 = a_q[2];
  assign w_1 = w_q[0];
  assign w_2 = w_q[1];
  assign w_3 = w_q[2];
  assign b_1 = b_q[0];
  assign b_2 = b_q[1];
  assign b_3 = b_q[2];

endmodule

`default_nettype wire

// File: doc/neuron_operand_loader.md
# neuron_operand_loader

Serial-to-parallel operand loader placed directly upstream of the three-input sigmoid neuron. It accepts one (activation, weight, bias) triplet per handshake beat and assembles three triplets into registered operand slots. It then holds all nine operands stable, with out_valid asserted, until the neuron-side consumer acknowledges. This lets a narrow streaming source drive the neuron's nine-operand combinational interface.

## Interface
Parameters:
- WIDTH, 32, signed two's-complement width of every operand (matches the neuron datapath).
- N_IN, 3, triplets per vector; fixed at 3 to match the neuron. Any other value is a compile-time error.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  source presents a triplet.
- in_ready  output  1  loader can accept a triplet this cycle.
- in_a  input  WIDTH signed  activation.
- in_w  input  WIDTH signed  weight.
- in_b  input  WIDTH signed  bias.
- a_1, a_2, a_3  output  WIDTH signed  registered activations, slot 1..3.
- w_1, w_2, w_3  output  WIDTH signed  registered weights.
- b_1, b_2, b_3  output  WIDTH signed  registered biases.
- out_valid  output  1  all three slots are loaded and stable.
- out_ready  input  1  consumer has captured the neuron result.
- in_last  input  1  (only with NEURON_LOADER_FRAME_EN) marks the third triplet of a vector.
- frame_err  output  1  (only with NEURON_LOADER_FRAME_EN) sticky framing error.

## Operation
- States: FILL and HOLD. A 2-bit index idx ranges 0..2.
- FILL
  - in_ready = 1.
  - A beat occurs on in_valid && in_ready; it writes in_a/in_w/in_b into slot idx+1.
  - idx 0 → 1 → 2; a beat at idx=2 sets idx=0 and moves to HOLD.
- HOLD
  - in_ready = 0, out_valid = 1.
  - All nine outputs are frozen.
  - out_ready=1 moves to FILL. Slot contents are kept but are stale.
- Slots are overwritten in place. Partially refilled vectors are never flagged valid.
- No arithmetic is performed; values pass bit-exact, with no truncation or sign change.
- Reset mid-vector: idx=0, state FILL, all slots cleared; the partial vector is discarded.
- in_valid while in HOLD is ignored. The source must hold its data under standard valid/ready rules.

## Timing
- Reset values:
  - All a_*/w_*/b_* = 0.
  - out_valid = 0, in_ready = 1 (combinational from FILL state after reset deassertion).
  - idx = 0; frame_err = 0.
- Latency: out_valid rises the cycle after the third accepted beat.
- Minimum period per vector is 4 cycles: 3 fill beats plus 1 HOLD cycle with out_ready=1.
- out_ready accepted in HOLD → in_ready = 1 on the next cycle. There is no same-cycle bypass: in_ready stays 0 in the acknowledge cycle.
- out_ready while out_valid=0 has no effect.
- in_ready and out_valid are derived from registered state only, with no combinational input-to-output path.

## Configuration
- NEURON_LOADER_FRAME_EN defined:
  - in_last and frame_err ports exist.
  - A beat with in_last=1 at idx≠2, or in_last=0 at idx=2, sets frame_err.
  - frame_err stays set until rst.
  - On in_last=1 at idx≠2, the vector is dropped: idx=0, remain in FILL.
  - Mismatch at idx=2 (in_last=0) still completes the vector.
- Undefined: neither port exists and framing comes purely from the index counter.

## Structure
- Shared package neuron_pkg:
  - WIDTH default.
  - N_IN = 3.
  - loader_state_t enum {FILL, HOLD}.
- One natural sub-module: operand_slot, a WIDTH×3 register with write-enable and asynchronous reset, instantiated three times.
- The FSM and index counter live in the top-level module.

## Test plan
- Reset then stream (1,2,3),(4,5,6),(-7,8,-9), out_ready=0 → out_valid=1 on the cycle after beat 3; a_1=1, w_2=5, b_3=-9; in_ready=0; values held for 10 cycles.
- Same vector, then out_ready=1 for one cycle → out_valid=0 and in_ready=1 next cycle; the next three beats produce a new vector 4 cycles after the first acknowledge.
- in_valid toggled 1,0,1,0,1 with distinct data → only the valid beats are stored; out_valid after the third valid beat.
- Assert rst asynchronously after 2 beats → outputs 0 immediately, idx=0; the next 3 beats form a fresh vector.
- Boundary values 0x7FFFFFFF and 0x80000000 → passed bit-exact to w_1/b_2.
- With NEURON_LOADER_FRAME_EN: in_last=1 on beat 2 → frame_err=1, out_valid stays 0; the next 3 beats with correct in_last → valid vector, frame_err remains 1.
